// File: rtl/alu_issue_stage.sv
// ID/EX issue register feeding the ALU, with RAW hazard resolution against the EX and MEM producers.
// Define ALU_ISSUE_FORWARD_EN to build the forwarding muxes; otherwise any match stalls.
module alu_issue_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  output logic             id_ready_o,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic             id_use_imm_i,
  input  logic [2:0]       id_func_i,
  input  logic             id_sub_en_i,
  input  logic             id_reg_wen_i,
  input  logic             id_is_load_i,
  input  logic [XLEN-1:0]  alu_dout_i,
  input  logic             mem_valid_i,
  input  logic             mem_reg_wen_i,
  input  logic [4:0]       mem_rd_i,
  input  logic [XLEN-1:0]  mem_result_i,
  input  logic             mem_data_ok_i,
  input  logic             ex_ready_i,
  output logic             ex_valid_o,
  output logic [2:0]       alu_func_o,
  output logic             alu_sub_en_o,
  output logic [XLEN-1:0]  alu_din1_o,
  output logic [XLEN-1:0]  alu_din2_o,
  output logic [XLEN-1:0]  ex_store_data_o,
  output logic [4:0]       ex_rd_o,
  output logic             ex_reg_wen_o,
  output logic             ex_is_load_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic            advance;
  logic            hazard;
  logic            capture;
  logic            selfRs1;
  logic            selfRs2;
  logic            memRs1;
  logic            memRs2;
  logic            hazRs1;
  logic            hazRs2;
  logic [XLEN-1:0] rs1Val;
  logic [XLEN-1:0] rs2Val;

  logic             exValid_q,   exValid_d;
  logic [2:0]       aluFunc_q,   aluFunc_d;
  logic             aluSubEn_q,  aluSubEn_d;
  logic [XLEN-1:0]  aluDin1_q,   aluDin1_d;
  logic [XLEN-1:0]  aluDin2_q,   aluDin2_d;
  logic [XLEN-1:0]  storeData_q, storeData_d;
  logic [4:0]       exRd_q,      exRd_d;
  logic             exRegWen_q,  exRegWen_d;
  logic             exIsLoad_q,  exIsLoad_d;
  logic [CNT_W-1:0] stallCnt_q,  stallCnt_d;

  // x0 is hard-wired zero, so a pending write to it never creates a dependency
  function automatic logic srcMatch(input logic valid, input logic wen,
                                    input logic [4:0] rd, input logic [4:0] rs);
    return valid & wen & (rs != 5'd0) & (rd == rs);
  endfunction

  always_comb begin
    selfRs1 = srcMatch(exValid_q, exRegWen_q, exRd_q, id_rs1_i);
    selfRs2 = srcMatch(exValid_q, exRegWen_q, exRd_q, id_rs2_i);
    memRs1  = srcMatch(mem_valid_i, mem_reg_wen_i, mem_rd_i, id_rs1_i);
    memRs2  = srcMatch(mem_valid_i, mem_reg_wen_i, mem_rd_i, id_rs2_i);
  end

`ifdef ALU_ISSUE_FORWARD_EN
  // The youngest producer wins; a load in EX has only an address, so it must stall
  always_comb begin
    rs1Val = id_rs1_data_i;
    rs2Val = id_rs2_data_i;
    hazRs1 = 1'b0;
    hazRs2 = 1'b0;
    if (selfRs1) begin
      rs1Val = alu_dout_i;
      hazRs1 = exIsLoad_q;
    end else if (memRs1) begin
      rs1Val = mem_result_i;
      hazRs1 = ~mem_data_ok_i;
    end
    if (selfRs2) begin
      rs2Val = alu_dout_i;
      hazRs2 = exIsLoad_q;
    end else if (memRs2) begin
      rs2Val = mem_result_i;
      hazRs2 = ~mem_data_ok_i;
    end
  end
`else
  logic unusedFwd;
  assign unusedFwd = ^{alu_dout_i, mem_result_i, mem_data_ok_i};

  always_comb begin
    rs1Val = id_rs1_data_i;
    rs2Val = id_rs2_data_i;
    hazRs1 = selfRs1 | memRs1;
    hazRs2 = selfRs2 | memRs2;
  end
`endif

  assign hazard     = hazRs1 | hazRs2;
  assign advance    = ~exValid_q | ex_ready_i;
  assign id_ready_o = advance & ~hazard & ~flush_i;
  assign capture    = id_valid_i & id_ready_o;

  // Datapath registers only load on capture; draining clears just the valid bit
  always_comb begin
    exValid_d   = exValid_q;
    aluFunc_d   = aluFunc_q;
    aluSubEn_d  = aluSubEn_q;
    aluDin1_d   = aluDin1_q;
    aluDin2_d   = aluDin2_q;
    storeData_d = storeData_q;
    exRd_d      = exRd_q;
    exRegWen_d  = exRegWen_q;
    exIsLoad_d  = exIsLoad_q;
    stallCnt_d  = stallCnt_q;

    if (flush_i) begin
      exValid_d = 1'b0;
    end else if (capture) begin
      exValid_d = 1'b1;
    end else if (ex_ready_i) begin
      exValid_d = 1'b0;
    end

    if (capture) begin
      aluFunc_d   = id_func_i;
      aluSubEn_d  = id_sub_en_i;
      aluDin1_d   = rs1Val;
      aluDin2_d   = id_use_imm_i ? id_imm_i : rs2Val;
      storeData_d = rs2Val;
      exRd_d      = id_rd_i;
      exRegWen_d  = id_reg_wen_i;
      exIsLoad_d  = id_is_load_i;
    end

    if (id_valid_i & hazard & advance & ~flush_i & (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exValid_q   <= 1'b0;
      aluFunc_q   <= '0;
      aluSubEn_q  <= 1'b0;
      aluDin1_q   <= '0;
      aluDin2_q   <= '0;
      storeData_q <= '0;
      exRd_q      <= '0;
      exRegWen_q  <= 1'b0;
      exIsLoad_q  <= 1'b0;
      stallCnt_q  <= '0;
    end else begin
      exValid_q   <= exValid_d;
      aluFunc_q   <= aluFunc_d;
      aluSubEn_q  <= aluSubEn_d;
      aluDin1_q   <= aluDin1_d;
      aluDin2_q   <= aluDin2_d;
      storeData_q <= storeData_d;
      exRd_q      <= exRd_d;
      exRegWen_q  <= exRegWen_d;
      exIsLoad_q  <= exIsLoad_d;
      stallCnt_q  <= stallCnt_d;
    end
  end

  assign ex_valid_o      = exValid_q;
  assign alu_func_o      = aluFunc_q;
  assign alu_sub_en_o    = aluSubEn_q;
  assign alu_din1_o      = aluDin1_q;
  assign alu_din2_o      = aluDin2_q;
  assign ex_store_data_o = storeData_q;
  assign ex_rd_o         = exRd_q;
  assign ex_reg_wen_o    = exRegWen_q;
  assign ex_is_load_o    = exIsLoad_q;
  assign stall_cnt_o     = stallCnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a scoreboard of expected issued instructions.
// Expectations follow ALU_ISSUE_FORWARD_EN when it is defined for the build.
module tb_alu_issue_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, flush, idValid, idReady;
  logic [4:0]       idRs1, idRs2, idRd;
  logic [XLEN-1:0]  idRs1Data, idRs2Data, idImm;
  logic             idUseImm, idSubEn, idRegWen, idIsLoad;
  logic [2:0]       idFunc;
  logic [XLEN-1:0]  aluDout, memResult;
  logic             memValid, memRegWen, memDataOk, exReady;
  logic [4:0]       memRd;
  logic             exValid, aluSubEn, exRegWen, exIsLoad;
  logic [2:0]       aluFunc;
  logic [XLEN-1:0]  aluDin1, aluDin2, exStoreData;
  logic [4:0]       exRd;
  logic [CNT_W-1:0] stallCnt;

  typedef struct packed {
    logic [2:0]  func;
    logic        sub;
    logic [31:0] din1;
    logic [31:0] din2;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        wen;
    logic        load;
  } expRec_t;

  expRec_t          scoreQ[$];
  expRec_t          held;
  expRec_t          nextRec;
  logic             expValid;
  logic [CNT_W-1:0] expStall;
  int               errors = 0;
  int               checks = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .id_valid_i(idValid), .id_ready_o(idReady),
    .id_rs1_i(idRs1), .id_rs2_i(idRs2), .id_rd_i(idRd),
    .id_rs1_data_i(idRs1Data), .id_rs2_data_i(idRs2Data), .id_imm_i(idImm),
    .id_use_imm_i(idUseImm), .id_func_i(idFunc), .id_sub_en_i(idSubEn),
    .id_reg_wen_i(idRegWen), .id_is_load_i(idIsLoad),
    .alu_dout_i(aluDout),
    .mem_valid_i(memValid), .mem_reg_wen_i(memRegWen), .mem_rd_i(memRd),
    .mem_result_i(memResult), .mem_data_ok_i(memDataOk),
    .ex_ready_i(exReady), .ex_valid_o(exValid),
    .alu_func_o(aluFunc), .alu_sub_en_o(aluSubEn),
    .alu_din1_o(aluDin1), .alu_din2_o(aluDin2), .ex_store_data_o(exStoreData),
    .ex_rd_o(exRd), .ex_reg_wen_o(exRegWen), .ex_is_load_o(exIsLoad),
    .stall_cnt_o(stallCnt)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                               input logic useImm, input logic [2:0] func, input logic sub,
                               input logic wen, input logic load);
    idValid   = 1'b1;
    idRs1     = rs1;
    idRs2     = rs2;
    idRd      = rd;
    idRs1Data = d1;
    idRs2Data = d2;
    idImm     = imm;
    idUseImm  = useImm;
    idFunc    = func;
    idSubEn   = sub;
    idRegWen  = wen;
    idIsLoad  = load;
  endtask

  task automatic setMem(input logic v, input logic [4:0] rd, input logic [31:0] res, input logic ok);
    memValid  = v;
    memRegWen = v;
    memRd     = rd;
    memResult = res;
    memDataOk = ok;
  endtask

  // Control fields come from the stimulus just driven, operand values are stated by the step
  task automatic setRec(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] st);
    nextRec = '{func: idFunc, sub: idSubEn, din1: d1, din2: d2, store: st,
                rd: idRd, wen: idRegWen, load: idIsLoad};
  endtask

  task automatic checkOutput(input logic captured);
    if (captured) begin
      if (scoreQ.size() == 0) begin
        checkVal("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        held = scoreQ.pop_front();
      end
    end
    checkVal("ex_valid",      {31'd0, exValid},  {31'd0, expValid});
    checkVal("stall_cnt",     {28'd0, stallCnt}, {28'd0, expStall});
    checkVal("alu_func",      {29'd0, aluFunc},  {29'd0, held.func});
    checkVal("alu_sub_en",    {31'd0, aluSubEn}, {31'd0, held.sub});
    checkVal("alu_din1",      aluDin1,           held.din1);
    checkVal("alu_din2",      aluDin2,           held.din2);
    checkVal("ex_store_data", exStoreData,       held.store);
    checkVal("ex_rd",         {27'd0, exRd},     {27'd0, held.rd});
    checkVal("ex_reg_wen",    {31'd0, exRegWen}, {31'd0, held.wen});
    checkVal("ex_is_load",    {31'd0, exIsLoad}, {31'd0, held.load});
  endtask

  // One clock: check id_ready before the edge, update the model, check registered outputs after
  task automatic step(input logic expReady, input logic hazStall);
    logic capture;
    logic nextValid;
    #1;
    checkVal("id_ready", {31'd0, idReady}, {31'd0, expReady});
    capture = idValid & expReady & ~flush;
    if (capture) scoreQ.push_back(nextRec);
    if (flush)          nextValid = 1'b0;
    else if (capture)   nextValid = 1'b1;
    else if (exReady)   nextValid = 1'b0;
    else                nextValid = expValid;
    if (hazStall && expStall != '1) expStall = expStall + 4'd1;
    @(posedge clk);
    #1;
    expValid = nextValid;
    checkOutput(capture);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst     = 1'b1;
    idValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expValid = 1'b0;
    expStall = '0;
    held     = '0;
    scoreQ.delete();
    checkOutput(1'b0);
    checkVal("id_ready_reset", {31'd0, idReady}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; exReady = 1'b1; aluDout = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    idValid = 1'b0;
    setMem(0, 0, 0, 1);
    held = '0; nextRec = '0; expValid = 1'b0; expStall = '0;
    @(negedge clk);
    doReset();

    // addi x1,x0,5
    applyStimulus(0, 0, 1, 0, 0, 5, 1, 3'b000, 0, 1, 0);
    setRec(0, 5, 0);
    step(1, 0);

    // add x2,x1,x1 directly behind the producer
    applyStimulus(1, 1, 2, 0, 0, 0, 0, 3'b000, 0, 1, 0);
    aluDout = 32'd5;
    setRec(5, 5, 5);
`ifdef ALU_ISSUE_FORWARD_EN
    step(1, 0);
`else
    step(0, 1);
    setMem(1, 1, 32'd5, 1);
    step(0, 1);
    setMem(0, 0, 0, 1);
    idRs1Data = 32'd5;
    idRs2Data = 32'd5;
    step(1, 0);
`endif

    // lw x3,8(x0)
    applyStimulus(0, 0, 3, 0, 0, 8, 1, 3'b000, 0, 1, 1);
    setRec(0, 8, 0);
    step(1, 0);

    // sub x4,x3,x0: load-use, then the load sits in MEM
    applyStimulus(3, 0, 4, 0, 0, 0, 0, 3'b000, 1, 1, 0);
    aluDout = 32'h0bad;
    step(0, 1);
    setMem(1, 3, 32'h0, 0);
    step(0, 1);
    setMem(1, 3, 32'h1234, 1);
    setRec(32'h1234, 0, 0);
`ifdef ALU_ISSUE_FORWARD_EN
    step(1, 0);
`else
    step(0, 1);
    setMem(0, 0, 0, 1);
    idRs1Data = 32'h1234;
    step(1, 0);
`endif
    setMem(0, 0, 0, 1);

    // addi x0,x0,7 then a reader of x0 with x0 writes pending in EX and MEM
    applyStimulus(0, 0, 0, 0, 0, 7, 1, 3'b000, 0, 1, 0);
    setRec(0, 7, 0);
    step(1, 0);
    applyStimulus(0, 0, 5, 0, 0, 0, 0, 3'b111, 0, 1, 0);
    setMem(1, 0, 32'hdead, 0);
    aluDout = 32'hbeef;
    setRec(0, 0, 0);
    step(1, 0);
    setMem(0, 0, 0, 1);

    // Downstream stall: nothing moves and nothing is counted
    exReady = 1'b0;
    applyStimulus(7, 8, 9, 32'h11, 32'h22, 0, 0, 3'b010, 0, 1, 0);
    setRec(32'h11, 32'h22, 32'h22);
    repeat (3) step(0, 0);
    flush = 1'b1;
    step(0, 0);
    exReady = 1'b1;
    step(0, 0);
    flush = 1'b0;
    step(1, 0);

    // Sustained MEM-not-ready hazard drives the counter into saturation
    applyStimulus(6, 0, 10, 32'h66, 0, 0, 0, 3'b100, 0, 1, 0);
    setMem(1, 6, 32'h0, 0);
    repeat (20) step(0, 1);
    checkVal("stall_saturated", {28'd0, stallCnt}, 32'd15);
    setMem(0, 0, 0, 1);
    setRec(32'h66, 0, 0);
    step(1, 0);

    // Reset drops the held instruction and clears the counter
    doReset();
    applyStimulus(0, 0, 1, 0, 0, 32'h3c, 1, 3'b001, 0, 1, 0);
    setRec(0, 32'h3c, 0);
    step(1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
